fizzbuzz_seq_ctrl: RTL and testbench
====================================

Name: fizzbuzz_seq_ctrl

Overview:
- Run controller for the fizz/buzz classification datapath.
- On a `start` command it latches a run configuration: fizz divisor, buzz divisor and beat count.
- It then sequences a value counter from 0 to limit-1 and emits one classified beat per value on a valid/ready stream, with full backpressure support.
- Replaces free-running counter use where downstream consumers need start/stop, abort and flow control. Classification uses per-divisor residue counters; no `%` operator.

Parameters:
- CNT_W, 8, width of value counter and `cfg_limit`.
- DIV_W, 4, width of divisor config fields and residue counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  terminate the current run; sampled only in RUN.
- cfg_fizz_div  input  DIV_W  fizz divisor; latched on accepted start.
- cfg_buzz_div  input  DIV_W  buzz divisor; latched on accepted start.
- cfg_limit  input  CNT_W  number of beats in the run; latched on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a run completes normally.
- cfg_err  output  1  one-cycle pulse when a start is rejected.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts beat.
- out_value  output  CNT_W  current value.
- out_fizz  output  1  value divisible by the fizz divisor.
- out_buzz  output  1  value divisible by the buzz divisor.
- out_fizzbuzz  output  1  `out_fizz` AND `out_buzz`.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - Value, residue counters and latched config are cleared.
- States: IDLE, RUN, DONE. `fire` = `out_valid` && `out_ready`.
- IDLE:
  - `busy`=0, `out_valid`=0.
  - `start`=1 with `cfg_fizz_div`==0, `cfg_buzz_div`==0 or `cfg_limit`==0: `cfg_err` pulses the next cycle and the block stays in IDLE.
  - Otherwise `start`=1 latches the config, sets value=0 and `fres`=`bres`=0, and goes to RUN. `out_valid` rises on the first RUN cycle, so there is 1 cycle of latency from start.
- RUN:
  - `out_valid`=1; `out_value`=value.
  - `out_fizz` = (`fres`==0); `out_buzz` = (`bres`==0). Value 0 is therefore always fizzbuzz.
  - Outputs are registered or derived purely from state registers; no combinational path from `out_ready`.
  - While `out_valid`=1 and `out_ready`=0, all `out_*` signals hold stable.
  - On `fire` with value != limit-1:
    - value increments.
    - `fres` = (`fres`==fdiv-1) ? 0 : `fres`+1; `bres` is updated the same way with bdiv.
  - On `fire` with value == limit-1: go to DONE.
  - `abort`=1: go to IDLE the next cycle, no `done`, `out_valid` falls. If `abort` and `fire` occur in the same cycle, the beat counts as transferred and abort still wins; no further beats follow.
- DONE: one cycle with `done`=1, `out_valid`=0, `busy`=1, then IDLE.
- `start` in RUN or DONE is ignored. Config input changes after the latch are ignored.
- Divisor 1 marks every beat. A divisor larger than limit marks only value 0.
- `cfg_limit`=2^CNT_W-1 is the maximum run. The value counter never wraps within a run.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Reset asserted mid-run: next cycle is IDLE with all outputs 0; no `done` pulse.

Test Plan:
- fdiv=3, bdiv=5, limit=16, `out_ready`=1 → 16 beats, values 0..15 on consecutive cycles:
  - fizz at 0,3,6,9,12,15;
  - buzz at 0,5,10,15;
  - fizzbuzz at 0,15;
  - `done` pulses 1 cycle after the value-15 beat, then `busy`=0.
- Same config, `out_ready` toggling in a pseudo-random pattern → identical value/flag sequence; outputs stable during every stalled cycle; no beat dropped or duplicated.
- Start with `cfg_buzz_div`=0, then separately with `cfg_limit`=0 → `cfg_err` 1-cycle pulse each time, `busy` stays 0, no beats.
- fdiv=1, bdiv=7, limit=8 → `out_fizz`=1 on all 8 beats; `out_buzz` at values 0 and 7 only; fizzbuzz at 0 and 7.
- Run limit=20; assert `abort` together with `fire` on value 4 → values 0..4 delivered, `out_valid`=0 the next cycle, no `done`. A new start then begins again at value 0.
- Mid-run, pulse `start` with different config, then assert `reset` at value 6 → the extra start has no effect on the sequence; after reset, state is IDLE with all outputs 0; a subsequent start runs cleanly from value 0.

Source files
------------

// File: rtl/fizzbuzz_seq_ctrl.sv
// Run controller for the fizz/buzz stream: latches a run config on start and
// emits one classified value per beat over a valid/ready handshake.
module fizzbuzz_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] cfg_fizz_div,
    input  logic [DIV_W-1:0] cfg_buzz_div,
    input  logic [CNT_W-1:0] cfg_limit,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_value,
    output logic             out_fizz,
    output logic             out_buzz,
    output logic             out_fizzbuzz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] value, value_nx;
    logic [CNT_W-1:0] limit, limit_nx;
    logic [DIV_W-1:0] fdiv, fdiv_nx;
    logic [DIV_W-1:0] bdiv, bdiv_nx;
    logic [DIV_W-1:0] fres, fres_nx;
    logic [DIV_W-1:0] bres, bres_nx;
    logic             err, err_nx;

    logic in_run;
    logic fire;
    logic last;
    logic cfg_bad;

    assign in_run  = (state == RUN);
    assign fire    = in_run && out_ready;
    assign last    = (value == limit - ONE_C);
    assign cfg_bad = (cfg_fizz_div == '0) ||
                     (cfg_buzz_div == '0) ||
                     (cfg_limit == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            value <= '0;
            limit <= '0;
            fdiv  <= '0;
            bdiv  <= '0;
            fres  <= '0;
            bres  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            value <= value_nx;
            limit <= limit_nx;
            fdiv  <= fdiv_nx;
            bdiv  <= bdiv_nx;
            fres  <= fres_nx;
            bres  <= bres_nx;
            err   <= err_nx;
        end
    end

    // Residues track value mod divisor incrementally; zero means divisible.
    always_comb begin
        state_nx = state;
        value_nx = value;
        limit_nx = limit;
        fdiv_nx  = fdiv;
        bdiv_nx  = bdiv;
        fres_nx  = fres;
        bres_nx  = bres;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_nx = 1'b1;
                    end else begin
                        fdiv_nx  = cfg_fizz_div;
                        bdiv_nx  = cfg_buzz_div;
                        limit_nx = cfg_limit;
                        value_nx = '0;
                        fres_nx  = '0;
                        bres_nx  = '0;
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (fire) begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        value_nx = value + ONE_C;
                        fres_nx  = (fres == fdiv - ONE_D) ? '0 : fres + ONE_D;
                        bres_nx  = (bres == bdiv - ONE_D) ? '0 : bres + ONE_D;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign cfg_err      = err;
    assign out_valid    = in_run;
    assign out_value    = in_run ? value : '0;
    assign out_fizz     = in_run && (fres == '0);
    assign out_buzz     = in_run && (bres == '0);
    assign out_fizzbuzz = out_fizz && out_buzz;

endmodule

// File: tb/tb_fizzbuzz_seq_ctrl.sv
// Directed bench for fizzbuzz_seq_ctrl: hand-computed flag masks per run,
// inputs driven and outputs sampled on the falling edge.
module tb_fizzbuzz_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] cfg_fizz_div;
    logic [3:0] cfg_buzz_div;
    logic [7:0] cfg_limit;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic       out_fizz;
    logic       out_buzz;
    logic       out_fizzbuzz;

    int checks = 0;
    int errs   = 0;

    // fdiv=3, bdiv=5 over values 0..19
    localparam logic [31:0] F35  = 32'h0004_9249;
    localparam logic [31:0] B35  = 32'h0000_8421;
    localparam logic [31:0] FB35 = 32'h0000_8001;
    // fdiv=1, bdiv=7 over values 0..7
    localparam logic [31:0] F17  = 32'h0000_00FF;
    localparam logic [31:0] B17  = 32'h0000_0081;
    localparam logic [31:0] FB17 = 32'h0000_0081;

    fizzbuzz_seq_ctrl #(.CNT_W(8), .DIV_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_fizz_div (cfg_fizz_div),
        .cfg_buzz_div (cfg_buzz_div),
        .cfg_limit    (cfg_limit),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_fizz     (out_fizz),
        .out_buzz     (out_buzz),
        .out_fizzbuzz (out_fizzbuzz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_value"}, 32'(out_value), 32'd0);
        chk({tag, "_flags"},
            32'({out_fizz, out_buzz, out_fizzbuzz}), 32'd0);
    endtask

    task automatic chk_beat(input int i, input logic [31:0] fm,
                            input logic [31:0] bm, input logic [31:0] fbm);
        chk("beat_valid", 32'(out_valid), 32'd1);
        chk("beat_busy", 32'(busy), 32'd1);
        chk("beat_value", 32'(out_value), 32'(i));
        chk("beat_fizz", 32'(out_fizz), 32'(fm[i]));
        chk("beat_buzz", 32'(out_buzz), 32'(bm[i]));
        chk("beat_fb", 32'(out_fizzbuzz), 32'(fbm[i]));
    endtask

    // Config inputs are scrambled right after the start cycle.
    task automatic start_run(input logic [3:0] f, input logic [3:0] b,
                             input logic [7:0] l);
        start        = 1'b1;
        cfg_fizz_div = f;
        cfg_buzz_div = b;
        cfg_limit    = l;
        @(negedge clk);
        start        = 1'b0;
        cfg_fizz_div = 4'd2;
        cfg_buzz_div = 4'd9;
        cfg_limit    = 8'd3;
    endtask

    task automatic run_beats(input int first, input int n,
                             input logic [31:0] fm, input logic [31:0] bm,
                             input logic [31:0] fbm);
        for (int i = first; i < first + n; i++) begin
            chk_beat(i, fm, bm, fbm);
            @(negedge clk);
        end
    endtask

    task automatic chk_done_then_idle(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] pat;
        int          idx;
        int          cyc;

        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b1;
        cfg_fizz_div = 4'd0;
        cfg_buzz_div = 4'd0;
        cfg_limit    = 8'd0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Full-rate run, 3/5 over 16 values
        start_run(4'd3, 4'd5, 8'd16);
        run_beats(0, 16, F35, B35, FB35);
        chk_done_then_idle("run35");

        // Same run with stalls
        pat = 32'b1011_0010_0110_1101_0011_1000_1101_0101;
        idx = 0;
        cyc = 0;
        start_run(4'd3, 4'd5, 8'd16);
        while (idx < 16 && cyc < 200) begin
            chk_beat(idx, F35, B35, FB35);
            out_ready = pat[cyc % 32];
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("stall_beats", 32'(idx), 32'd16);
        out_ready = 1'b1;
        chk_done_then_idle("stall");

        // Rejected starts
        start_run(4'd3, 4'd0, 8'd16);
        chk("err_bdiv_pulse", 32'(cfg_err), 32'd1);
        chk("err_bdiv_busy", 32'(busy), 32'd0);
        chk("err_bdiv_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_idle("err_bdiv_after");
        start_run(4'd3, 4'd5, 8'd0);
        chk("err_lim_pulse", 32'(cfg_err), 32'd1);
        chk("err_lim_busy", 32'(busy), 32'd0);
        chk("err_lim_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_idle("err_lim_after");

        // Divisor 1 and a divisor near the limit
        start_run(4'd1, 4'd7, 8'd8);
        run_beats(0, 8, F17, B17, FB17);
        chk_done_then_idle("run17");

        // Abort together with a transfer on value 4
        start_run(4'd3, 4'd5, 8'd20);
        run_beats(0, 4, F35, B35, FB35);
        chk_beat(4, F35, B35, FB35);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        @(negedge clk);
        chk_idle("abort_late");
        start_run(4'd3, 4'd5, 8'd16);
        run_beats(0, 16, F35, B35, FB35);
        chk_done_then_idle("after_abort");

        // Stray start mid-run, then reset at value 6
        start_run(4'd3, 4'd5, 8'd16);
        run_beats(0, 2, F35, B35, FB35);
        chk_beat(2, F35, B35, FB35);
        start        = 1'b1;
        cfg_fizz_div = 4'd2;
        cfg_buzz_div = 4'd2;
        cfg_limit    = 8'd4;
        @(negedge clk);
        start = 1'b0;
        run_beats(3, 3, F35, B35, FB35);
        chk_beat(6, F35, B35, FB35);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("mid_reset");
        @(negedge clk);
        chk_idle("mid_reset_late");
        start_run(4'd1, 4'd7, 8'd8);
        run_beats(0, 8, F17, B17, FB17);
        chk_done_then_idle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
